mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 34 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the preferred port and
// flips to the other port after every taken grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_e ptr;

  always_comb begin
    gnt = 2'b00;
    if (ptr == PORT_F) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PORT_F;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0] ? PORT_D : PORT_F;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one synchronous-read memory between a
// read-only fetch port and a read/write data port (IDLE -> ACCESS -> RESP).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out
);

  state_e state_q;
  state_e state_d;

  logic [1:0]        gnt;
  logic              grant;
  logic              in_idle;

  port_e             port_p1;
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] rdata_p2;

  assign in_idle = (state_q == IDLE);
  assign grant   = in_idle && (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({d_req, f_req}),
    .advance (in_idle),
    .gnt     (gnt)
  );

  // Request capture into the access stage; fetch requests are always reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_p1  <= PORT_F;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (grant) begin
      port_p1  <= gnt[1] ? PORT_D : PORT_F;
      we_p1    <= gnt[1] & d_we;
      addr_p1  <= gnt[1] ? d_addr : f_addr;
      wdata_p1 <= gnt[1] ? d_wdata : '0;
    end
  end

  // Access stage -> response stage: read data or zero write acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p2 <= '0;
    end else if (state_q == ACCESS) begin
      rdata_p2 <= we_p1 ? '0 : mem_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if ((port_p1 == PORT_F) ? f_rsp_ready : d_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    f_ready     = in_idle & gnt[0];
    d_ready     = in_idle & gnt[1];
    f_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    rsp_rdata   = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    if (state_q == ACCESS) begin
      mem_rd   = ~we_p1;
      mem_wr   = we_p1;
      mem_addr = addr_p1;
      mem_data = we_p1 ? wdata_p1 : '0;
    end
    if (state_q == RESP) begin
      f_rsp_valid = (port_p1 == PORT_F);
      d_rsp_valid = (port_p1 == PORT_D);
      rsp_rdata   = rdata_p2;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req, f_ready, f_rsp_valid, f_rsp_ready;
  logic [AW-1:0] f_addr;
  logic          d_req, d_we, d_ready, d_rsp_valid, d_rsp_ready;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;

  bit [DW-1:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .rsp_rdata(rsp_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  always_comb mem_out = mem_rd ? mem[mem_addr] : '0;
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every sample point also runs the cycle-level protocol rules.
  task automatic neg();
    @(negedge clk);
    checks++;
    if ((mem_rd && mem_wr) || (f_rsp_valid && d_rsp_valid) || (f_ready && d_ready) ||
        ((f_ready || d_ready) && (mem_rd || mem_wr || f_rsp_valid || d_rsp_valid))) begin
      errors++;
      $display("FAIL protocol: rd=%0b wr=%0b frv=%0b drv=%0b frdy=%0b drdy=%0b (t=%0t)",
               mem_rd, mem_wr, f_rsp_valid, d_rsp_valid, f_ready, d_ready, $time);
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, 64'({f_ready, d_ready, f_rsp_valid, d_rsp_valid, mem_rd, mem_wr}), 64'(0));
    chk({name, "_data"}, 64'({rsp_rdata, mem_data}), 64'(0));
    chk({name, "_addr"}, 64'(mem_addr), 64'(0));
  endtask

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [7];

  // Single transaction from IDLE with a ready consumer: N, N+1, N+2 checks.
  task automatic run_txn(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    neg();
    chk({tag, "_ready"}, 64'({f_ready, d_ready}), 64'(v.is_d ? 2'b01 : 2'b10));
    pos();
    f_req = 1'b0; d_req = 1'b0;
    neg();
    chk({tag, "_memctl"}, 64'({mem_rd, mem_wr}), 64'({~v.we, v.we}));
    chk({tag, "_memaddr"}, 64'(mem_addr), 64'(v.addr));
    chk({tag, "_memdata"}, 64'(mem_data), 64'(v.we ? v.wdata : '0));
    chk({tag, "_early_rsp"}, 64'({f_rsp_valid, d_rsp_valid}), 64'(0));
    neg();
    chk({tag, "_rsp"}, 64'({f_rsp_valid, d_rsp_valid}), 64'(v.is_d ? 2'b01 : 2'b10));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.exp));
    chk({tag, "_memidle"}, 64'({mem_rd, mem_wr}), 64'(0));
    pos();
  endtask

  // Reference model state for the randomized run.
  int            ptr, cyc, acc_cyc, idx;
  bit            busy, o_d, o_we, ef, ed, f_acc, d_acc;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_exp;
  logic [DW-1:0] ref_mem [8];

  initial begin
    idle_inputs();
    f_addr = '0; d_addr = '0; d_wdata = '0;
    neg();
    chk_all_zero("reset");
    pos();
    rst_n = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 16'd15,     32'd123,        32'd0};
    tbl[1] = '{1'b1, 1'b0, 16'd15,     32'd0,          32'd123};
    tbl[2] = '{1'b1, 1'b1, 16'd16,     32'd223,        32'd0};
    tbl[3] = '{1'b0, 1'b0, 16'd16,     32'd0,          32'd223};
    tbl[4] = '{1'b1, 1'b1, 16'hFFFF,   32'hFFFF_FFFF,  32'd0};
    tbl[5] = '{1'b0, 1'b0, 16'hFFFF,   32'd0,          32'hFFFF_FFFF};
    tbl[6] = '{1'b1, 1'b0, 16'd0,      32'd0,          32'd0};
    for (int i = 0; i < 7; i++) run_txn(tbl[i], i);

    // Backpressure on the fetch response with a data request waiting
    f_req = 1'b1; f_addr = 16'd16; f_rsp_ready = 1'b0;
    neg();
    chk("bp_f_ready", 64'({f_ready, d_ready}), 64'(2'b10));
    pos();
    f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'd15;
    neg();
    chk("bp_access_noready", 64'({f_ready, d_ready}), 64'(0));
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bp_hold_valid", 64'({f_rsp_valid, d_rsp_valid}), 64'(2'b10));
      chk("bp_hold_rdata", 64'(rsp_rdata), 64'(223));
      chk("bp_hold_noready", 64'({f_ready, d_ready}), 64'(0));
    end
    pos();
    f_rsp_ready = 1'b1;
    neg();
    chk("bp_release_valid", 64'(f_rsp_valid), 64'(1));
    neg();
    chk("bp_pending_d", 64'({f_ready, d_ready}), 64'(2'b01));
    pos();
    d_req = 1'b0;
    neg();
    neg();
    chk("bp_d_rsp", 64'({f_rsp_valid, d_rsp_valid}), 64'(2'b01));
    chk("bp_d_rdata", 64'(rsp_rdata), 64'(123));
    pos();

    // Reset arriving while a write is on the memory bus
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd20; d_wdata = 32'hA5A5_0001;
    neg();
    chk("rma_ready", 64'(d_ready), 64'(1));
    pos();
    d_req = 1'b0; d_we = 1'b0;
    chk("rma_wr_before", 64'({mem_wr, mem_addr}), 64'({1'b1, 16'd20}));
    rst_n = 1'b0;
    #1;
    chk("rma_wr_dropped", 64'(mem_wr), 64'(0));
    chk_all_zero("rma");
    pos();
    pos();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("rma_no_rsp", 64'({f_rsp_valid, d_rsp_valid}), 64'(0));
    end

    // Contention straight after reset, then again with fetch re-requesting
    pos();
    f_req = 1'b1; f_addr = 16'd16; d_req = 1'b1; d_we = 1'b0; d_addr = 16'd15;
    neg();
    chk("cont1_fetch_first", 64'({f_ready, d_ready}), 64'(2'b10));
    neg();
    neg();
    chk("cont1_f_rsp", 64'({f_rsp_valid, d_rsp_valid, rsp_rdata}), 64'({2'b10, 32'd223}));
    neg();
    chk("cont2_data_first", 64'({f_ready, d_ready}), 64'(2'b01));
    pos();
    d_req = 1'b0;
    neg();
    neg();
    chk("cont2_d_rsp", 64'({f_rsp_valid, d_rsp_valid, rsp_rdata}), 64'({2'b01, 32'd123}));
    neg();
    chk("cont2_loser_next", 64'({f_ready, d_ready}), 64'(2'b10));
    pos();
    f_req = 1'b0;
    neg();
    neg();
    chk("cont2_f_rsp", 64'({f_rsp_valid, d_rsp_valid, rsp_rdata}), 64'({2'b10, 32'd223}));
    pos();

    // Randomized traffic on addresses 100..107 against the reference model
    rst_n = 1'b0;
    idle_inputs();
    pos();
    pos();
    rst_n = 1'b1;
    ptr = 0; busy = 1'b0; cyc = 0; acc_cyc = 0; f_acc = 1'b0; d_acc = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    for (int n = 0; n < 1500; n++) begin
      if (f_acc) f_req = 1'b0;
      if (d_acc) d_req = 1'b0;
      if (!f_req && ($urandom_range(0, 2) == 0)) begin
        f_req = 1'b1; f_addr = AW'(100 + $urandom_range(0, 7));
      end
      if (!d_req && ($urandom_range(0, 2) == 0)) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = AW'(100 + $urandom_range(0, 7)); d_wdata = $urandom;
      end
      f_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
      neg();
      cyc++;
      if (!busy) begin
        ef = f_req && ((ptr == 0) || !d_req);
        ed = d_req && !ef;
        chk("rnd_ready", 64'({f_ready, d_ready}), 64'({ef, ed}));
        chk("rnd_idle_rsp", 64'({f_rsp_valid, d_rsp_valid}), 64'(0));
        if (ef || ed) begin
          busy = 1'b1;
          o_d = ed;
          o_we = ed && d_we;
          o_addr = ed ? d_addr : f_addr;
          o_wdata = d_wdata;
          idx = int'(o_addr) - 100;
          o_exp = o_we ? '0 : ref_mem[idx];
          if (o_we) ref_mem[idx] = d_wdata;
          acc_cyc = cyc;
          ptr = ed ? 0 : 1;
        end
      end else begin
        chk("rnd_busy_noready", 64'({f_ready, d_ready}), 64'(0));
        if (cyc == acc_cyc + 1) begin
          chk("rnd_memctl", 64'({mem_rd, mem_wr}), 64'({~o_we, o_we}));
          chk("rnd_memaddr", 64'(mem_addr), 64'(o_addr));
          chk("rnd_memdata", 64'(mem_data), 64'(o_we ? o_wdata : '0));
          chk("rnd_early_rsp", 64'({f_rsp_valid, d_rsp_valid}), 64'(0));
        end else begin
          chk("rnd_rsp", 64'({f_rsp_valid, d_rsp_valid}), 64'({~o_d, o_d}));
          chk("rnd_rdata", 64'(rsp_rdata), 64'(o_exp));
          if (o_d ? d_rsp_ready : f_rsp_ready) busy = 1'b0;
        end
      end
      f_acc = f_ready;
      d_acc = d_ready;
      pos();
    end

    idle_inputs();
    pos();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
